// File: rtl/lfrag_cfg_sequencer.sv
// Loads 16-bit LUT truth tables into a bank of L_FRAG configuration registers and,
// when VERIFY_EN is set, sweeps all 16 input patterns through the written fragment,
// checking LUTOutput and CarryOut against the table before reporting a result.
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   cfg_valid/ready         write request handshake; cfg_idx/cfg_data sampled on accept
//   frag_cfg                fragBitInfo bus, fragment n on [16n+15:16n]
//   test_mode/sel/in        input override towards the logic-cell array during the sweep
//   lut_out, carry_out      per-fragment outputs observed during the sweep
//   rsp_valid/ready         result handshake; rsp_code/rsp_pat held while rsp_valid
module lfrag_cfg_sequencer #(
    parameter int unsigned NUM_FRAGS = 4,
    parameter int unsigned IDX_W     = 2,
    parameter int unsigned VERIFY_EN = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [IDX_W-1:0]       cfg_idx,
    input  logic [15:0]            cfg_data,
    output logic [16*NUM_FRAGS-1:0] frag_cfg,
    output logic                   test_mode,
    output logic [IDX_W-1:0]       test_sel,
    output logic [3:0]             test_in,
    input  logic [NUM_FRAGS-1:0]   lut_out,
    input  logic [NUM_FRAGS-1:0]   carry_out,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [1:0]             rsp_code,
    output logic [3:0]             rsp_pat
);

    localparam logic [1:0] CodeOk       = 2'd0;
    localparam logic [1:0] CodeBadIdx   = 2'd1;
    localparam logic [1:0] CodeLutMis   = 2'd2;
    localparam logic [1:0] CodeCarryMis = 2'd3;

    typedef enum logic [1:0] {StIdle, StSweep, StReport} state_e;

    state_e                  state_q, state_d;
    logic [16*NUM_FRAGS-1:0] cfg_q, cfg_d;
    logic [15:0]             data_q, data_d;
    logic [IDX_W-1:0]        sel_q, sel_d;
    logic [3:0]              pat_q, pat_d;
    logic [1:0]              code_q, code_d;
    logic [3:0]              rpat_q, rpat_d;
    logic                    sel_lut;
    logic                    sel_carry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cfg_q   <= '0;
            data_q  <= '0;
            sel_q   <= '0;
            pat_q   <= '0;
            code_q  <= CodeOk;
            rpat_q  <= '0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            pat_q   <= pat_d;
            code_q  <= code_d;
            rpat_q  <= rpat_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cfg_d     = cfg_q;
        data_d    = data_q;
        sel_d     = sel_q;
        pat_d     = pat_q;
        code_d    = code_q;
        rpat_d    = rpat_q;
        sel_lut   = 1'b0;
        sel_carry = 1'b0;

        // Decoded select keeps indexing in range whatever NUM_FRAGS is.
        for (int n = 0; n < int'(NUM_FRAGS); n++) begin
            if (sel_q == IDX_W'(n)) begin
                sel_lut   = lut_out[n];
                sel_carry = carry_out[n];
            end
        end

        unique case (state_q)
            StIdle: begin
                if (cfg_valid) begin
                    if (32'(cfg_idx) >= NUM_FRAGS) begin
                        state_d = StReport;
                        code_d  = CodeBadIdx;
                        rpat_d  = '0;
                    end else begin
                        for (int n = 0; n < int'(NUM_FRAGS); n++) begin
                            if (cfg_idx == IDX_W'(n)) cfg_d[16*n +: 16] = cfg_data;
                        end
                        data_d = cfg_data;
                        sel_d  = cfg_idx;
                        if (VERIFY_EN != 0) begin
                            pat_d   = '0;
                            state_d = StSweep;
                        end else begin
                            state_d = StReport;
                            code_d  = CodeOk;
                            rpat_d  = '0;
                        end
                    end
                end
            end
            StSweep: begin
                // CarryOut ignores I3, so it always reflects the upper half of the table.
                if (sel_lut != data_q[pat_q]) begin
                    state_d = StReport;
                    code_d  = CodeLutMis;
                    rpat_d  = pat_q;
                end else if (sel_carry != data_q[{1'b1, pat_q[2:0]}]) begin
                    state_d = StReport;
                    code_d  = CodeCarryMis;
                    rpat_d  = pat_q;
                end else if (pat_q == 4'hF) begin
                    state_d = StReport;
                    code_d  = CodeOk;
                    rpat_d  = '0;
                end else begin
                    pat_d = pat_q + 4'd1;
                end
            end
            StReport: begin
                if (rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign cfg_ready = (state_q == StIdle);
    assign test_mode = (state_q == StSweep);
    assign rsp_valid = (state_q == StReport);
    assign frag_cfg  = cfg_q;
    assign test_sel  = sel_q;
    assign test_in   = pat_q;
    assign rsp_code  = code_q;
    assign rsp_pat   = rpat_q;

endmodule

// File: tb/tb_lfrag_cfg_sequencer.sv
// Bench for lfrag_cfg_sequencer with three fragments, so index 3 is out of range.
// Fragments are modelled as ideal LUT4s read from frag_cfg, with per-pattern fault masks
// that flip LUTOutput / CarryOut of the fragment under test.
module tb_lfrag_cfg_sequencer;

    localparam int NF = 3;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cfg_valid = 1'b0;
    logic            cfg_ready;
    logic [IW-1:0]   cfg_idx = '0;
    logic [15:0]     cfg_data = '0;
    logic [16*NF-1:0] frag_cfg;
    logic            test_mode;
    logic [IW-1:0]   test_sel;
    logic [3:0]      test_in;
    logic [NF-1:0]   lut_out;
    logic [NF-1:0]   carry_out;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [1:0]      rsp_code;
    logic [3:0]      rsp_pat;

    logic [IW-1:0]   flt_idx = '0;
    logic [15:0]     flt_lut = '0;
    logic [15:0]     flt_car = '0;

    logic [15:0]     ref_cfg [NF];
    logic [3:0]      exp_tin;
    logic [IW-1:0]   exp_tsel;
    int              checks = 0;
    int              errors = 0;

    typedef struct {
        logic [IW-1:0] idx;
        logic [15:0]   data;
        logic [15:0]   lutf;
        logic [15:0]   carf;
        int            hold;
        logic [1:0]    code;
        logic [3:0]    pat;
        int            lat;
    } vec_t;

    vec_t vecs [7];

    lfrag_cfg_sequencer #(
        .NUM_FRAGS(NF),
        .IDX_W    (IW),
        .VERIFY_EN(1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_idx  (cfg_idx),
        .cfg_data (cfg_data),
        .frag_cfg (frag_cfg),
        .test_mode(test_mode),
        .test_sel (test_sel),
        .test_in  (test_in),
        .lut_out  (lut_out),
        .carry_out(carry_out),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_code (rsp_code),
        .rsp_pat  (rsp_pat)
    );

    always #5 clk = ~clk;

    // Ideal L_FRAGs: LUTOutput = table[I3..I0], CarryOut = table[8 + I2..I0].
    always_comb begin
        lut_out   = '0;
        carry_out = '0;
        for (int n = 0; n < NF; n++) begin
            lut_out[n]   = frag_cfg[16*n + int'(test_in)];
            carry_out[n] = frag_cfg[16*n + 8 + int'(test_in[2:0])];
            if (n == int'(flt_idx)) begin
                lut_out[n]   = lut_out[n] ^ flt_lut[test_in];
                carry_out[n] = carry_out[n] ^ flt_car[test_in];
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp_v);
        end
    endtask

    function automatic logic [16*NF-1:0] pack_ref();
        logic [16*NF-1:0] b;
        for (int n = 0; n < NF; n++) b[16*n +: 16] = ref_cfg[n];
        return b;
    endfunction

    // Expected result from the sweep rules: first pattern whose observed output disagrees
    // with the table wins, LUT before carry; latency is edges after the accept edge.
    task automatic model(input logic [IW-1:0] idx, input logic [15:0] data,
                         input logic [15:0] lutf, input logic [15:0] carf,
                         output logic [1:0] code, output logic [3:0] pat, output int lat);
        logic obs_l, obs_c;
        code = 2'd0;
        pat  = 4'd0;
        lat  = 16;
        if (int'(idx) >= NF) begin
            code = 2'd1;
            lat  = 0;
            return;
        end
        for (int k = 0; k < 16; k++) begin
            obs_l = data[k] ^ lutf[k];
            obs_c = data[8 + (k % 8)] ^ carf[k];
            if (obs_l != data[k]) begin
                code = 2'd2;
                pat  = 4'(k);
                lat  = k + 1;
                return;
            end
            if (obs_c != data[8 + (k % 8)]) begin
                code = 2'd3;
                pat  = 4'(k);
                lat  = k + 1;
                return;
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_frag_cfg"}, 64'(frag_cfg), 64'd0);
        chk({tag, "_test_mode"}, 64'(test_mode), 64'd0);
        chk({tag, "_test_sel"}, 64'(test_sel), 64'd0);
        chk({tag, "_test_in"}, 64'(test_in), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_rsp_code"}, 64'(rsp_code), 64'd0);
        chk({tag, "_rsp_pat"}, 64'(rsp_pat), 64'd0);
    endtask

    // Called at a negedge with the DUT idle.
    task automatic run_txn(input string tag, input logic [IW-1:0] idx, input logic [15:0] data,
                           input logic [15:0] lutf, input logic [15:0] carf, input int hold,
                           input logic [1:0] e_code, input logic [3:0] e_pat, input int e_lat);
        int cyc;
        flt_idx = idx;
        flt_lut = lutf;
        flt_car = carf;
        chk({tag, "_cfg_ready_idle"}, 64'(cfg_ready), 64'd1);
        cfg_valid = 1'b1;
        cfg_idx   = idx;
        cfg_data  = data;
        @(negedge clk);
        cfg_valid = 1'b0;
        cfg_idx   = IW'($urandom);
        cfg_data  = 16'($urandom);
        if (int'(idx) < NF) begin
            ref_cfg[idx] = data;
            exp_tsel     = idx;
            exp_tin      = (e_code == 2'd0) ? 4'hF : e_pat;
        end
        cyc = 0;
        while (!rsp_valid && cyc < 40) begin
            chk({tag, "_sweep_test_mode"}, 64'(test_mode), 64'd1);
            chk({tag, "_sweep_test_in"}, 64'(test_in), 64'(cyc));
            chk({tag, "_sweep_test_sel"}, 64'(test_sel), 64'(idx));
            chk({tag, "_sweep_frag_cfg"}, 64'(frag_cfg), 64'(pack_ref()));
            cyc++;
            @(negedge clk);
        end
        chk({tag, "_latency"}, 64'(cyc), 64'(e_lat));
        chk({tag, "_rsp_code"}, 64'(rsp_code), 64'(e_code));
        chk({tag, "_rsp_pat"}, 64'(rsp_pat), 64'(e_pat));
        chk({tag, "_report_test_mode"}, 64'(test_mode), 64'd0);
        chk({tag, "_report_cfg_ready"}, 64'(cfg_ready), 64'd0);
        chk({tag, "_frag_cfg"}, 64'(frag_cfg), 64'(pack_ref()));
        chk({tag, "_test_in_hold"}, 64'(test_in), 64'(exp_tin));
        chk({tag, "_test_sel_hold"}, 64'(test_sel), 64'(exp_tsel));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, "_hold_rsp_valid"}, 64'(rsp_valid), 64'd1);
            chk({tag, "_hold_rsp_code"}, 64'(rsp_code), 64'(e_code));
            chk({tag, "_hold_rsp_pat"}, 64'(rsp_pat), 64'(e_pat));
            chk({tag, "_hold_cfg_ready"}, 64'(cfg_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_post_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_post_cfg_ready"}, 64'(cfg_ready), 64'd1);
    endtask

    initial begin
        logic [IW-1:0] r_idx;
        logic [15:0]   r_data, r_lutf, r_carf;
        logic [1:0]    m_code;
        logic [3:0]    m_pat;
        int            m_lat, cyc;

        for (int n = 0; n < NF; n++) ref_cfg[n] = '0;
        exp_tin  = '0;
        exp_tsel = '0;

        //           idx    data      lutf      carf      hold code  pat   lat
        vecs[0] = '{2'd0, 16'h8000, 16'h0000, 16'h0000, 0, 2'd0, 4'd0, 16};
        vecs[1] = '{2'd1, 16'hFFFF, 16'hFFFF, 16'h0000, 0, 2'd2, 4'd0, 1};
        vecs[2] = '{2'd2, 16'hFF00, 16'h0000, 16'hFFFF, 0, 2'd3, 4'd0, 1};
        vecs[3] = '{2'd3, 16'hABCD, 16'h0000, 16'h0000, 1, 2'd1, 4'd0, 0};
        vecs[4] = '{2'd0, 16'h8000, 16'h0000, 16'h0000, 5, 2'd0, 4'd0, 16};
        vecs[5] = '{2'd1, 16'h1234, 16'h0200, 16'h0020, 2, 2'd3, 4'd5, 6};
        vecs[6] = '{2'd2, 16'hA5C3, 16'h0080, 16'h0080, 0, 2'd2, 4'd7, 8};

        #12;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_cfg_ready", 64'(cfg_ready), 64'd1);

        for (int i = 0; i < 7; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].idx, vecs[i].data, vecs[i].lutf,
                    vecs[i].carf, vecs[i].hold, vecs[i].code, vecs[i].pat, vecs[i].lat);
        end

        for (int i = 0; i < 40; i++) begin
            r_idx  = IW'($urandom_range(0, 3));
            r_data = 16'($urandom);
            r_lutf = '0;
            r_carf = '0;
            case ($urandom_range(0, 3))
                1: r_lutf = 16'd1 << $urandom_range(0, 15);
                2: r_carf = 16'd1 << $urandom_range(0, 15);
                3: begin
                    r_lutf = 16'd1 << $urandom_range(0, 15);
                    r_carf = 16'd1 << $urandom_range(0, 15);
                end
                default: ;
            endcase
            model(r_idx, r_data, r_lutf, r_carf, m_code, m_pat, m_lat);
            run_txn($sformatf("rnd%0d", i), r_idx, r_data, r_lutf, r_carf,
                    $urandom_range(0, 3), m_code, m_pat, m_lat);
        end

        // Reset in the middle of a sweep.
        flt_idx   = 2'd1;
        flt_lut   = '0;
        flt_car   = '0;
        cfg_valid = 1'b1;
        cfg_idx   = 2'd1;
        cfg_data  = 16'h6996;
        @(negedge clk);
        cfg_valid = 1'b0;
        cyc = 0;
        while (test_in != 4'd7 && cyc < 20) begin
            cyc++;
            @(negedge clk);
        end
        chk("midrst_reach_pat7", 64'(test_in), 64'd7);
        chk("midrst_in_sweep", 64'(test_mode), 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        for (int n = 0; n < NF; n++) ref_cfg[n] = '0;
        exp_tin  = '0;
        exp_tsel = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("midrst_no_rsp", 64'(rsp_valid), 64'd0);
            chk("midrst_no_test_mode", 64'(test_mode), 64'd0);
        end
        chk("midrst_cfg_ready", 64'(cfg_ready), 64'd1);
        run_txn("after_rst", vecs[0].idx, vecs[0].data, vecs[0].lutf, vecs[0].carf,
                vecs[0].hold, vecs[0].code, vecs[0].pat, vecs[0].lat);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
